vit_frame_ctrl: RTL and testbench
=================================

Name: vit_frame_ctrl

Overview:
- Frame-level sequencer for the 64-state Viterbi decoder.
- Accepts received symbol pairs with a valid/ready handshake and drives the registered rx_pair bus to the BMC array.
- Issues one ACS step per accepted symbol, generates survivor-memory write addresses and path-metric normalisation, and flags the tail region.
- Hands each completed frame to the traceback unit, then waits for it to finish before starting the next frame.

Parameters:
FRAME_LEN, 64, trellis steps per frame, tail steps included (>= TAIL_LEN+1)
TAIL_LEN, 6, zero-forced tail steps at end of frame (K-1 for K=7)
ADDR_W, 6, survivor memory address width (2**ADDR_W >= FRAME_LEN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream symbol valid
in_ready  out  1  controller can accept a symbol
rx_pair_in  in  2  upstream received symbol pair
rx_pair  out  2  registered symbol pair to BMC array
acs_init  out  1  one-cycle pulse: load initial path metrics (state 0 = 0, others = max)
acs_en  out  1  ACS array updates path metrics this cycle
norm_req  in  1  ACS array reports a path metric over the normalisation threshold
norm_en  out  1  ACS subtracts the normalisation constant on this step
tail_mode  out  1  current ACS step is a tail step (ACS keeps only bit-0 branches)
surv_wr_en  out  1  write ACS decisions to survivor memory
surv_wr_addr  out  ADDR_W  survivor write address = step index
tb_start  out  1  one-cycle pulse: frame complete, start traceback
tb_done  in  1  traceback finished
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (synchronous, priority over everything):
  - State = IDLE; step counter = 0.
  - All outputs 0: in_ready, rx_pair, acs_init, acs_en, norm_en, tail_mode, surv_wr_en, surv_wr_addr, tb_start, busy.
  - Reset mid-frame abandons the frame; no tb_start is issued for it.
- States: IDLE, INIT, RUN, TB_WAIT.
- IDLE:
  - in_ready = 0.
  - in_valid = 1 -> INIT (symbol not consumed).
- INIT (one cycle):
  - acs_init = 1; counter cleared -> RUN.
- RUN:
  - in_ready = 1. Accept = in_valid & in_ready at cycle N.
  - Each accept registers:
    - rx_pair <= rx_pair_in;
    - at N+1: acs_en = surv_wr_en = 1, surv_wr_addr = counter value at N;
    - norm_en at N+1 = norm_req sampled at N;
    - tail_mode at N+1 = 1 iff counter >= FRAME_LEN-TAIL_LEN at N.
  - Counter increments on accept.
  - No accept: acs_en, surv_wr_en, norm_en, tail_mode = 0 at N+1; rx_pair holds.
  - Accept with counter = FRAME_LEN-1: counter -> 0, state -> TB_WAIT at N+1, in_ready = 0 from N+1.
- TB_WAIT:
  - tb_start = 1 exactly at N+2, one cycle after the final acs_en.
  - tb_done is ignored in the tb_start cycle and earlier.
  - First tb_done = 1 after that -> IDLE next cycle.
  - in_valid held high in IDLE re-enters INIT: minimum frame gap = 3 cycles (IDLE, INIT, first RUN accept).
- One-cycle pulses: acs_init, acs_en, surv_wr_en and tb_start are never asserted two cycles in a row except acs_en/surv_wr_en on back-to-back accepts.
- Throughput: one symbol per cycle in RUN. Frame latency from first accept to tb_start = FRAME_LEN+1 cycles with no valid gaps.
- Widths: counter is ADDR_W bits; surv_wr_addr never exceeds FRAME_LEN-1.
- Never asserted together: acs_init with acs_en; tb_start with acs_en.

Test Plan:
- Reset: assert rst 2 cycles mid-RUN with in_valid = 1 -> all outputs 0 next cycle; no tb_start; fresh INIT on the following in_valid.
- Full frame, FRAME_LEN = 8, TAIL_LEN = 2, continuous valid from cycle 0:
  - acs_init at cycle 1; accepts at cycles 2-9;
  - acs_en with addresses 0..7 at cycles 3-10; tail_mode high on addresses 6,7;
  - tb_start at cycle 11 only.
- Valid gaps: drop in_valid every other cycle -> acs_en only after accepts; addresses contiguous 0..7; rx_pair holds during gaps; tb_start one cycle after the 8th acs_en.
- Normalisation: norm_req high at the accept of step 3 only -> norm_en high only together with the address-3 acs_en.
- Backpressure: in_valid held high through TB_WAIT, tb_done after 20 cycles -> in_ready = 0 throughout; IDLE, INIT, then accept of step 0 within 3 cycles of leaving TB_WAIT.
- Early tb_done: tb_done held high from the final accept -> ignored until the cycle after tb_start; then IDLE.

Source files
------------

// File: rtl/vit_frame_ctrl.sv
// Frame sequencer for the 64-state Viterbi decoder.
// Feeds symbols to BMC/ACS, addresses survivor memory, hands frames to traceback.
module vit_frame_ctrl #(
  parameter int FRAME_LEN = 64,
  parameter int TAIL_LEN  = 6,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        rx_pair_in,
  output logic [1:0]        rx_pair,
  output logic              acs_init,
  output logic              acs_en,
  input  logic              norm_req,
  output logic              norm_en,
  output logic              tail_mode,
  output logic              surv_wr_en,
  output logic [ADDR_W-1:0] surv_wr_addr,
  output logic              tb_start,
  input  logic              tb_done,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    RUN,
    TB_WAIT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] TAIL0 = ADDR_W'(FRAME_LEN - TAIL_LEN);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              accept;
  logic              last_acc;
  logic              fin;
  logic              armed;

  assign accept   = in_valid & in_ready;
  assign last_acc = accept & (cnt == LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; tb_done only counts once the tb_start cycle has passed
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = INIT;
      INIT:    state_nxt = RUN;
      RUN:     if (last_acc) state_nxt = TB_WAIT;
      TB_WAIT: if (armed && tb_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    in_ready = 1'b0;
    acs_init = 1'b0;
    busy     = 1'b0;
    in_ready = (state == RUN);
    acs_init = (state == INIT);
    busy     = (state != IDLE);
  end

  // Step counter: cleared in INIT, wraps to 0 on the final accept
  always_ff @(posedge clk) begin
    if (rst)                 cnt <= '0;
    else if (state == INIT)  cnt <= '0;
    else if (accept)         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  // Per-accept ACS/survivor controls, registered one cycle after the accept
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_pair      <= '0;
      acs_en       <= 1'b0;
      surv_wr_en   <= 1'b0;
      norm_en      <= 1'b0;
      tail_mode    <= 1'b0;
      surv_wr_addr <= '0;
      fin          <= 1'b0;
      tb_start     <= 1'b0;
    end else begin
      acs_en     <= accept;
      surv_wr_en <= accept;
      norm_en    <= accept & norm_req;
      tail_mode  <= accept & (cnt >= TAIL0);
      if (accept) begin
        rx_pair      <= rx_pair_in;
        surv_wr_addr <= cnt;
      end
      fin      <= last_acc;
      tb_start <= fin;
    end
  end

  // Arms traceback-done acceptance from the cycle after tb_start
  always_ff @(posedge clk) begin
    if (rst) armed <= 1'b0;
    else     armed <= (state_nxt == TB_WAIT) && (armed || tb_start);
  end

endmodule

// File: tb/tb_vit_frame_ctrl.sv
// Testbench for vit_frame_ctrl (FRAME_LEN=8, TAIL_LEN=2).
// Timeline table for one frame, directed corner cases and random traffic.
module tb_vit_frame_ctrl;

  localparam int F = 8;
  localparam int T = 2;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    rx_pair_in = 2'b00;
  logic [1:0]    rx_pair;
  logic          acs_init;
  logic          acs_en;
  logic          norm_req = 1'b0;
  logic          norm_en;
  logic          tail_mode;
  logic          surv_wr_en;
  logic [AW-1:0] surv_wr_addr;
  logic          tb_start;
  logic          tb_done = 1'b0;
  logic          busy;

  int checks = 0;
  int errors = 0;

  vit_frame_ctrl #(
    .FRAME_LEN(F),
    .TAIL_LEN(T),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .rx_pair_in(rx_pair_in),
    .rx_pair(rx_pair),
    .acs_init(acs_init),
    .acs_en(acs_en),
    .norm_req(norm_req),
    .norm_en(norm_en),
    .tail_mode(tail_mode),
    .surv_wr_en(surv_wr_en),
    .surv_wr_addr(surv_wr_addr),
    .tb_start(tb_start),
    .tb_done(tb_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 init, 2 run, 3 waiting for traceback
  int            m_ph;
  int            m_cnt;
  int            m_age;
  logic          m_acs;
  logic          m_norm;
  logic          m_tail;
  logic          m_tbs;
  logic [AW-1:0] m_addr;
  logic [1:0]    m_pair;

  function automatic logic [12:0] obs();
    return {in_ready, acs_init, busy, acs_en, surv_wr_en, norm_en,
            tail_mode, tb_start, surv_wr_addr, rx_pair};
  endfunction

  function automatic logic [12:0] mexp();
    return {m_ph == 2, m_ph == 1, m_ph != 0, m_acs, m_acs, m_norm,
            m_tail, m_tbs, m_addr, m_pair};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_cnt = 0; m_age = 0;
    m_acs = 0; m_norm = 0; m_tail = 0; m_tbs = 0;
    m_addr = '0; m_pair = '0;
  endtask

  task automatic model_step(input logic r, input logic v,
                            input logic [1:0] p, input logic n,
                            input logic d);
    logic acc;
    if (r) begin
      model_reset();
      return;
    end
    acc    = (m_ph == 2) && v;
    m_acs  = acc;
    m_norm = acc && n;
    m_tail = acc && (m_cnt >= F - T);
    if (acc) begin
      m_addr = AW'(m_cnt);
      m_pair = p;
    end
    m_tbs = (m_ph == 3) && (m_age == 0);
    case (m_ph)
      0: if (v) m_ph = 1;
      1: begin m_ph = 2; m_cnt = 0; end
      2: if (acc) begin
           m_cnt++;
           if (m_cnt == F) begin m_ph = 3; m_cnt = 0; m_age = 0; end
         end
      default: if (d && m_age >= 2) m_ph = 0; else m_age++;
    endcase
  endtask

  task automatic tick(input logic r, input logic v, input logic [1:0] p,
                      input logic n, input logic d,
                      input logic [12:0] want, input string tag);
    @(negedge clk);
    checks++;
    if (obs() !== want) begin
      errors++;
      $display("FAIL %s t=%0t: got %b want %b", tag, $time, obs(), want);
    end
    rst = r; in_valid = v; rx_pair_in = p; norm_req = n; tb_done = d;
    model_step(r, v, p, n, d);
  endtask

  task automatic mtick(input logic r, input logic v, input logic [1:0] p,
                       input logic n, input logic d, input string tag);
    tick(r, v, p, n, d, mexp(), tag);
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  pair;
    logic        done;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Frame timeline with continuous valid from cycle 0
    for (int c = 0; c < 15; c++) begin
      logic ir, ini, bs, ac, tl, ts;
      logic [2:0] ad;
      logic [1:0] rp;
      ir  = (c >= 2 && c <= 9);
      ini = (c == 1);
      bs  = (c >= 1 && c <= 12);
      ac  = (c >= 3 && c <= 10);
      tl  = (c >= 9 && c <= 10);
      ts  = (c == 11);
      ad  = (c < 3) ? 3'd0 : (c <= 10) ? 3'(c - 3) : 3'd7;
      rp  = (c < 3) ? 2'd0 : (c <= 10) ? 2'((c - 1) % 4) : 2'd1;
      tbl[c].v    = (c <= 11);
      tbl[c].pair = 2'(c % 4);
      tbl[c].done = (c == 12);
      tbl[c].exp  = {ir, ini, bs, ac, ac, 1'b0, tl, ts, ad, rp};
    end

    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();

    for (int c = 0; c < 15; c++)
      tick(1'b0, tbl[c].v, tbl[c].pair, 1'b0, tbl[c].done, tbl[c].exp,
           (c == 0) ? "reset_state" : "frame_table");

    // Valid every other cycle
    for (int i = 0; i < 24; i++)
      mtick(1'b0, (i % 2) == 0, 2'($urandom_range(0, 3)), 1'b0, 1'b0, "gaps");
    for (int i = 0; i < 3; i++)
      mtick(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, "gaps_done");

    // Normalisation request only at the accept of step 3
    for (int i = 0; i < 16; i++)
      mtick(1'b0, 1'b1, 2'($urandom_range(0, 3)),
            (m_ph == 2) && (m_cnt == 3), 1'b0, "norm");
    for (int i = 0; i < 4; i++)
      mtick(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, "norm_done");

    // Backpressure: valid held through a long traceback
    for (int i = 0; i < 45; i++)
      mtick(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b0,
            (m_ph == 3) && (m_age >= 20), "backpressure");
    for (int i = 0; i < 10; i++)
      mtick(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, "bp_drain");

    // Early tb_done held from the final accept
    for (int i = 0; i < 22; i++)
      mtick(1'b0, i < 12, 2'($urandom_range(0, 3)), 1'b0,
            (m_ph == 3) || ((m_ph == 2) && (m_cnt == F - 1)), "early_done");

    // Reset in the middle of RUN with valid high
    for (int i = 0; i < 8; i++)
      mtick(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0, "pre_reset");
    mtick(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, "pre_reset");
    mtick(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, "mid_reset");
    for (int i = 0; i < 16; i++)
      mtick(1'b0, 1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0, "post_reset");
    for (int i = 0; i < 4; i++)
      mtick(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, "post_reset_done");

    // Random traffic
    for (int i = 0; i < 3000; i++)
      mtick(($urandom % 300) == 0, ($urandom % 10) < 7,
            2'($urandom_range(0, 3)), ($urandom % 5) == 0,
            ($urandom % 10) < 3, "random");
    mtick(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, "random_tail");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
